// File: rtl/c1541_pkg.sv
// Shared definitions for the 1541 SD-port sharing logic: arbiter states and
// fixed widths of the MiSTer SD block interface.
package c1541_pkg;

  localparam int unsigned MAX_DRIVES = 4;
  localparam int unsigned LBA_W      = 32;
  localparam int unsigned BUFF_AW    = 9;

  typedef enum logic [2:0] {
    StFlush,
    StIdle,
    StIssue,
    StXfer,
    StGap
  } arb_state_e;

endpackage

// File: rtl/c1541_rr_pick.sv
// Combinational round-robin picker: returns the first requester at or after
// rr_ptr, wrapping modulo NDRIVES.
module c1541_rr_pick
  import c1541_pkg::*;
#(
  parameter int unsigned NDRIVES = 2,
  parameter int unsigned GW      = 2
) (
  input  logic [NDRIVES-1:0] req,
  input  logic [GW-1:0]      rr_ptr,
  output logic               any,
  output logic [GW-1:0]      idx
);

  localparam int unsigned NSLOT = 1 << GW;

  logic [NSLOT-1:0] req_pad;
  logic [GW-1:0]    cand;

  // Pad to a power of two so a GW-bit index always selects a real bit.
  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    if (i < NDRIVES) begin : g_drv
      assign req_pad[i] = req[i];
    end else begin : g_pad
      assign req_pad[i] = 1'b0;
    end
  end

  function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NDRIVES) sum = sum - NDRIVES;
    return GW'(sum);
  endfunction

  // Scan from the far end back toward rr_ptr so the nearest hit is written last.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int unsigned k = NDRIVES; k > 0; k--) begin
      cand = wrap_add(rr_ptr, k - 1);
      if (req_pad[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/c1541_sd_arbiter.sv
// Shares the single MiSTer SD block port between several c1541_sd drives,
// granting one drive per transfer in round-robin order.
module c1541_sd_arbiter
  import c1541_pkg::*;
#(
  parameter int unsigned NDRIVES = 2,
  parameter int unsigned GW      = 2
) (
  input  logic                     clk32,
  input  logic                     reset,
  input  logic [NDRIVES*LBA_W-1:0] drv_lba,
  input  logic [NDRIVES-1:0]       drv_rd,
  input  logic [NDRIVES-1:0]       drv_wr,
  output logic [NDRIVES-1:0]       drv_ack,
  input  logic [NDRIVES*8-1:0]     drv_buff_din,
  output logic [BUFF_AW-1:0]       drv_buff_addr,
  output logic [7:0]               drv_buff_dout,
  output logic [NDRIVES-1:0]       drv_buff_wr,
  output logic [LBA_W-1:0]         sd_lba,
  output logic                     sd_rd,
  output logic                     sd_wr,
  input  logic                     sd_ack,
  input  logic [BUFF_AW-1:0]       sd_buff_addr,
  input  logic [7:0]               sd_buff_dout,
  output logic [7:0]               sd_buff_din,
  input  logic                     sd_buff_wr,
  output logic [GW-1:0]            grant,
  output logic                     busy
);

  localparam int unsigned NSLOT = 1 << GW;

  arb_state_e state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [LBA_W-1:0] lba_q, lba_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;

  logic [NDRIVES-1:0]          req;
  logic                        pick_any;
  logic [GW-1:0]               pick_idx;
  logic                        routed;
  logic [NSLOT-1:0]            rd_pad, wr_pad;
  logic [NSLOT-1:0][LBA_W-1:0] lba_pad;
  logic [NSLOT-1:0][7:0]       din_pad;

  assign req = drv_rd | drv_wr;

  c1541_rr_pick #(
    .NDRIVES (NDRIVES),
    .GW      (GW)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  // Per-drive views padded to NSLOT entries so grant/pick indices never run off the end.
  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    if (i < NDRIVES) begin : g_drv
      assign rd_pad[i]  = drv_rd[i];
      assign wr_pad[i]  = drv_wr[i];
      assign lba_pad[i] = drv_lba[LBA_W*i +: LBA_W];
      assign din_pad[i] = drv_buff_din[8*i +: 8];
      assign drv_ack[i]     = routed && (grant_q == GW'(i)) && sd_ack;
      assign drv_buff_wr[i] = routed && (grant_q == GW'(i)) && sd_buff_wr;
    end else begin : g_pad
      assign rd_pad[i]  = 1'b0;
      assign wr_pad[i]  = 1'b0;
      assign lba_pad[i] = '0;
      assign din_pad[i] = '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    lba_d    = lba_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    case (state_q)
      // Let a transfer that was running across reset drain before arbitrating.
      StFlush: begin
        if (!sd_ack) state_d = StIdle;
      end
      StIdle: begin
        if (pick_any) begin
          grant_d = pick_idx;
          lba_d   = lba_pad[pick_idx];
          wr_d    = wr_pad[pick_idx];
          rd_d    = rd_pad[pick_idx] & ~wr_pad[pick_idx];
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (sd_ack) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (!sd_ack) begin
          lba_d    = '0;
          rr_ptr_d = (grant_q == GW'(NDRIVES - 1)) ? '0 : grant_q + 1'b1;
          state_d  = StGap;
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StFlush;
      end
    endcase
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      state_q  <= StFlush;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      lba_q    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      lba_q    <= lba_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
    end
  end

  assign routed        = (state_q == StIssue) || (state_q == StXfer);
  assign sd_buff_din   = routed ? din_pad[grant_q] : 8'h00;
  assign drv_buff_addr = sd_buff_addr;
  assign drv_buff_dout = sd_buff_dout;
  assign sd_lba        = lba_q;
  assign sd_rd         = rd_q;
  assign sd_wr         = wr_q;
  assign grant         = grant_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_c1541_sd_arbiter.sv
// Randomized bench for c1541_sd_arbiter against a transaction-level
// round-robin model, plus directed reset/contention/read scenarios.
module tb_c1541_sd_arbiter;

  localparam int N  = 3;
  localparam int GW = 2;

  logic            clk32 = 1'b0;
  logic            reset;
  logic [N*32-1:0] drv_lba;
  logic [N-1:0]    drv_rd, drv_wr, drv_ack, drv_buff_wr;
  logic [N*8-1:0]  drv_buff_din;
  logic [8:0]      drv_buff_addr, sd_buff_addr;
  logic [7:0]      drv_buff_dout, sd_buff_dout, sd_buff_din;
  logic [31:0]     sd_lba;
  logic            sd_rd, sd_wr, sd_ack, sd_buff_wr, busy;
  logic [GW-1:0]   grant;

  int n_checks = 0;
  int n_errors = 0;
  int model_rr = 0;
  int obs_g;
  int exp_seq[4] = '{0, 1, 0, 1};

  always #5 clk32 = ~clk32;

  c1541_sd_arbiter #(
    .NDRIVES (N),
    .GW      (GW)
  ) dut (
    .clk32         (clk32),
    .reset         (reset),
    .drv_lba       (drv_lba),
    .drv_rd        (drv_rd),
    .drv_wr        (drv_wr),
    .drv_ack       (drv_ack),
    .drv_buff_din  (drv_buff_din),
    .drv_buff_addr (drv_buff_addr),
    .drv_buff_dout (drv_buff_dout),
    .drv_buff_wr   (drv_buff_wr),
    .sd_lba        (sd_lba),
    .sd_rd         (sd_rd),
    .sd_wr         (sd_wr),
    .sd_ack        (sd_ack),
    .sd_buff_addr  (sd_buff_addr),
    .sd_buff_dout  (sd_buff_dout),
    .sd_buff_din   (sd_buff_din),
    .sd_buff_wr    (sd_buff_wr),
    .grant         (grant),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk32);
    @(negedge clk32);
  endtask

  function automatic int rr_pick_model(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      int i = (ptr + k) % N;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  // Entered at a negedge with the arbiter in IDLE and at least one request up.
  task automatic run_xact(input int beats, input bit withdraw, input bit poke_lba,
                          output int g_seen);
    logic [N-1:0] req;
    logic [31:0]  exp_lba;
    logic         exp_rd, exp_wr;
    int           g;
    req     = drv_rd | drv_wr;
    g       = rr_pick_model(req, model_rr);
    exp_lba = drv_lba[32*g +: 32];
    exp_wr  = drv_wr[g];
    exp_rd  = drv_rd[g] & ~drv_wr[g];
    step();
    g_seen = int'(grant);
    check("issue_grant", grant, g);
    check("issue_lba", sd_lba, exp_lba);
    check("issue_wr", sd_wr, exp_wr);
    check("issue_rd", sd_rd, exp_rd);
    check("issue_busy", busy, 1);
    check("issue_ack_low", drv_ack, 0);
    if (withdraw) begin
      drv_rd[g] = 1'b0;
      drv_wr[g] = 1'b0;
    end
    if (poke_lba) drv_lba[32*g +: 32] = $urandom;
    repeat ($urandom_range(0, 3)) begin
      step();
      check("hold_rdwr", {sd_rd, sd_wr}, {exp_rd, exp_wr});
      check("hold_lba", sd_lba, exp_lba);
    end
    sd_ack = 1'b1;
    #1;
    check("ack_route", drv_ack, 64'(1) << g);
    step();
    check("xfer_rdwr", {sd_rd, sd_wr}, 0);
    for (int b = 0; b < beats; b++) begin
      sd_buff_wr   = 1'($urandom_range(0, 1));
      sd_buff_addr = 9'($urandom);
      sd_buff_dout = 8'($urandom);
      drv_buff_din = (N*8)'($urandom);
      #1;
      check("bwr_route", drv_buff_wr, sd_buff_wr ? (64'(1) << g) : 64'(0));
      check("din_mux", sd_buff_din, drv_buff_din[8*g +: 8]);
      check("addr_pass", drv_buff_addr, sd_buff_addr);
      check("dout_pass", drv_buff_dout, sd_buff_dout);
      check("ack_hold", drv_ack, 64'(1) << g);
      step();
    end
    sd_buff_wr = 1'b0;
    sd_ack     = 1'b0;
    #1;
    check("ack_fall", drv_ack, 0);
    step();
    model_rr = (g + 1) % N;
    sd_buff_wr = 1'b1;
    #1;
    check("gap_busy", busy, 1);
    check("gap_rdwr", {sd_rd, sd_wr}, 0);
    check("gap_bwr", drv_buff_wr, 0);
    check("gap_din", sd_buff_din, 0);
    sd_buff_wr = 1'b0;
    step();
    check("idle_busy", busy, 0);
    check("idle_rdwr", {sd_rd, sd_wr}, 0);
    check("idle_lba", sd_lba, 0);
    check("idle_din", sd_buff_din, 0);
  endtask

  // Reset with the host still acknowledging, then let the flush drain.
  task automatic reset_flush();
    sd_ack     = 1'b1;
    sd_buff_wr = 1'b1;
    reset      = 1'b1;
    step();
    check("rst_rdwr", {sd_rd, sd_wr}, 0);
    check("rst_lba", sd_lba, 0);
    check("rst_busy", busy, 1);
    check("rst_grant", grant, 0);
    check("rst_ack", drv_ack, 0);
    check("rst_bwr", drv_buff_wr, 0);
    reset = 1'b0;
    repeat (3) begin
      step();
      check("flush_rdwr", {sd_rd, sd_wr}, 0);
      check("flush_ack", drv_ack, 0);
      check("flush_bwr", drv_buff_wr, 0);
      check("flush_busy", busy, 1);
    end
    sd_buff_wr = 1'b0;
    sd_ack     = 1'b0;
    step();
    check("flush_exit_busy", busy, 0);
    check("flush_exit_rd", sd_rd, 0);
    model_rr = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    sd_ack       = 1'b0;
    sd_buff_wr   = 1'b0;
    sd_buff_addr = '0;
    sd_buff_dout = '0;
    drv_buff_din = '0;
    drv_lba      = '0;
    drv_rd       = 3'b010;
    drv_wr       = '0;
    drv_lba[32 +: 32] = 32'h0000_0456;

    // Power-up reset with a pending drive 1 request held off by the flush.
    reset_flush();
    run_xact(4, 1'b0, 1'b0, obs_g);
    check("first_grant", obs_g, 1);

    // Contention: drive 0 reads, drive 1 writes, both held.
    drv_rd = 3'b001;
    drv_wr = 3'b010;
    for (int k = 0; k < 4; k++) begin
      run_xact(3, 1'b0, 1'b0, obs_g);
      check("contention_seq", obs_g, exp_seq[k]);
    end

    // Withdrawal during ISSUE, then a full 512-byte read for drive 0.
    drv_wr = '0;
    drv_rd = 3'b001;
    run_xact(3, 1'b1, 1'b1, obs_g);
    drv_rd = 3'b001;
    drv_lba[0 +: 32] = 32'h0000_0123;
    run_xact(512, 1'b0, 1'b0, obs_g);

    for (int it = 0; it < 60; it++) begin
      for (int d = 0; d < N; d++) begin
        if ($urandom_range(0, 2) != 0) begin
          drv_rd[d] = 1'($urandom_range(0, 1));
          drv_wr[d] = 1'($urandom_range(0, 1));
        end
        drv_lba[32*d +: 32] = $urandom;
      end
      if ((drv_rd | drv_wr) == '0) begin
        step();
        check("norq_busy", busy, 0);
        check("norq_rdwr", {sd_rd, sd_wr}, 0);
      end else begin
        run_xact($urandom_range(1, 12), $urandom_range(0, 3) == 0,
                 1'($urandom_range(0, 1)), obs_g);
      end
    end

    // Reset in the middle of a transfer; only drive 1 remains pending.
    drv_rd = 3'b011;
    drv_wr = '0;
    step();
    sd_ack = 1'b1;
    step();
    drv_rd = 3'b010;
    reset_flush();
    run_xact(5, 1'b0, 1'b0, obs_g);
    check("post_reset_grant", obs_g, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/c1541_sd_arbiter.md
Name: c1541_sd_arbiter

Overview:
- Shares the single MiSTer SD block port (sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_*) between NDRIVES instances of c1541_sd, for multi-drive configurations such as drives 8 and 9.
- Each drive keeps its own track cache and issues sector requests as if it owned the port.
- The arbiter grants one drive at a time, round-robin, and holds the grant from issue until the host completes the transfer.
- While a grant is held, it routes the acknowledge and the buffer streams to the granted drive only.

Parameters:
- NDRIVES, 2, number of drive requesters, 1..4.
- GW, 2, grant index width; must satisfy 2**GW >= NDRIVES.

Ports:
- clk32  in  1  system clock.
- reset  in  1  synchronous, active-high.
- drv_lba  in  NDRIVES*32  per-drive sector LBA; drive i occupies bits [32*i+31:32*i].
- drv_rd  in  NDRIVES  per-drive read request, level-held.
- drv_wr  in  NDRIVES  per-drive write request, level-held.
- drv_ack  out  NDRIVES  per-drive acknowledge.
- drv_buff_din  in  NDRIVES*8  per-drive write data toward the host.
- drv_buff_addr  out  9  broadcast copy of sd_buff_addr.
- drv_buff_dout  out  8  broadcast copy of sd_buff_dout.
- drv_buff_wr  out  NDRIVES  per-drive gated buffer write strobe.
- sd_lba  out  32  host LBA.
- sd_rd  out  1  host read request.
- sd_wr  out  1  host write request.
- sd_ack  in  1  host acknowledge; high for the whole transfer.
- sd_buff_addr  in  9  host buffer address.
- sd_buff_dout  in  8  host read data.
- sd_buff_din  out  8  host write data, muxed from the granted drive.
- sd_buff_wr  in  1  host buffer write strobe.
- grant  out  GW  index of the current or last granted drive.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - state=FLUSH, grant=0, rr_ptr=0.
  - sd_rd=0, sd_wr=0, sd_lba=0, busy=1.
  - drv_ack=0, drv_buff_wr=0.
- States: FLUSH, IDLE, ISSUE, XFER, GAP.
- FLUSH (entered from reset): wait until sd_ack=0, then go to IDLE the next cycle. This absorbs a host transfer that was in flight when reset asserted. sd_buff_wr is ignored in FLUSH.
- IDLE:
  - req[i] = drv_rd[i] | drv_wr[i].
  - If any req bit is set, pick the first i with req[i]=1, scanning i = rr_ptr, rr_ptr+1, ... modulo NDRIVES.
  - Register grant=i, sd_lba=drv_lba[i], sd_wr=drv_wr[i], sd_rd=drv_rd[i]&~drv_wr[i]. Write wins if both are set.
  - Go to ISSUE. Request-to-sd_rd/sd_wr latency is exactly 1 cycle.
  - With no request, stay in IDLE and hold all outputs at their reset values (busy=0).
- ISSUE:
  - Hold sd_rd/sd_wr/sd_lba until sd_ack=1.
  - On the cycle sd_ack is sampled 1, clear sd_rd and sd_wr and go to XFER.
  - No timeout; waiting is unbounded.
- XFER:
  - On the sd_ack 1->0 transition, go to GAP.
  - Advance rr_ptr to grant+1, wrapping NDRIVES-1 -> 0.
- GAP: one cycle with everything deasserted, then IDLE. This guarantees the host sees rd/wr low for at least 2 cycles between commands.
- Routing (combinational, valid in ISSUE and XFER only; all zero in other states):
  - drv_ack[grant] = sd_ack; every other drv_ack bit = 0.
  - drv_buff_wr[grant] = sd_buff_wr; every other drv_buff_wr bit = 0.
  - sd_buff_din = drv_buff_din[grant]. Outside ISSUE/XFER, sd_buff_din = 0.
  - drv_buff_addr and drv_buff_dout are always passed straight through.
- Request capture:
  - LBA and direction are captured once, in IDLE.
  - Changes to drv_lba, or the drive dropping its request during ISSUE or XFER, are ignored; the transfer still completes.
  - A drive that keeps its request level high after completion is re-arbitrated normally and loses to other pending drives under round-robin.
- Reset mid-transfer: all outputs return to reset values on the next edge, state becomes FLUSH, and no drive receives drv_ack until a new grant.
- NDRIVES=1: the arbiter degenerates to a pass-through with the ISSUE/XFER/GAP sequencing intact; grant stays at 0.

Decomposition:
- Shared package c1541_pkg holds:
  - the state enum (FLUSH, IDLE, ISSUE, XFER, GAP);
  - MAX_DRIVES=4;
  - the LBA width constant 32 and the buffer address width constant 9.
- One sub-module, c1541_rr_pick: combinational round-robin picker.
  - Inputs: req[NDRIVES], rr_ptr[GW].
  - Outputs: any, idx[GW].
  - Reusable by future shared resources such as ROM upload.

Test Plan:
- Single read: drv_rd[0]=1, drv_lba[0]=0x00000123 → sd_rd=1 and sd_lba=0x123 one cycle later. Host ack high for 512 cycles with sd_buff_wr pulses → only drv_buff_wr[0] toggles, drv_ack[0] mirrors sd_ack, and drv_ack[1] stays 0. After the ack falls: GAP, then IDLE, busy=0.
- Contention: drv_rd[0] and drv_wr[1] asserted in the same cycle with rr_ptr=0, both held → grants come out 0, 1, 0, 1 on back-to-back transfers. sd_wr=1 only during drive 1's grants.
- Write data path: grant drive 1 for a write, drv_buff_din[1]=0xA5, drv_buff_din[0]=0x3C → sd_buff_din=0xA5 throughout XFER, and 0x00 in IDLE.
- Rd and wr together: drv_rd[0]=drv_wr[0]=1 → sd_wr=1, sd_rd=0.
- Withdrawal: drive 0 drops drv_rd in ISSUE → sd_rd stays high until sd_ack=1, and the transfer completes normally.
- Reset mid-XFER with sd_ack still high → outputs 0, state FLUSH. A pending drv_rd[1] is not issued until 1 cycle after sd_ack falls.
